simon_round_controller: RTL and testbench
=========================================

Name: simon_round_controller

Overview:
- Sequences one Simon game: generates a random colour sequence, plays it back and checks the player's presses against it.
- Each round lengthens the sequence by one entry.
- Drives simon_turn, simon_num and simon_pressed, which the top level muxes onto the shared LED and speaker datapath. Also raises game_over and win.
- Runs on the system clock; all timing is counted in tick pulses.

Parameters:
- MAX_LEN, 16: maximum sequence length; reaching it wins the game.
- ON_TICKS, 3: ticks each playback tone and LED stay on.
- OFF_TICKS, 1: ticks of silence before and between playback entries.
- TIMEOUT_TICKS, 20: ticks allowed in WAIT_PRESS before game over.
- SEED, 8'hA5: LFSR reset value; must be non-zero.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- tick  input  1  single-cycle enable pulse from the clock reducer; timing base.
- player_num  input  2  decoded button index.
- player_pressed  input  1  level; high while any button is held.
- simon_turn  output  1  1 = controller owns LEDs/speaker; 0 = player owns them.
- simon_num  output  2  colour currently played back.
- simon_pressed  output  1  playback tone/LED active.
- game_over  output  1  wrong press or timeout.
- win  output  1  MAX_LEN round completed.
- level  output  5  current sequence length, 1..MAX_LEN.

Behaviour:
- Reset:
  - Outputs after reset: simon_turn=1, simon_num=0, simon_pressed=0, game_over=0, win=0, level=1.
  - State=GEN, LFSR=SEED, idx=0, all counters 0.
  - Reset mid-operation aborts everything. The sequence memory contents are don't-care.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every clk cycle, so its value depends on player timing.
  - GEN writes lfsr[1:0] into mem[level-1].
- Player input edges:
  - player_pressed is registered once. A press edge is prev=0 and cur=1; a release edge is prev=1 and cur=0.
  - player_num is sampled in the press-edge cycle.
  - Edges seen while simon_turn=1 are discarded, except in OVER and WIN.
- Output timing: all outputs are registered. An event seen in cycle n is visible on the outputs at n+1.
- State machine:
  - GEN: one clk cycle. Stores the new entry, sets idx=0 and goes to GAP.
  - GAP: simon_pressed=0. After OFF_TICKS ticks goes to ON with simon_num=mem[idx].
  - ON: simon_pressed=1. After ON_TICKS ticks, drops simon_pressed.
    - If idx<level-1: idx++ and go to GAP.
    - Otherwise: idx=0, simon_turn=0, clear the timeout counter and go to WAIT_PRESS.
  - WAIT_PRESS: counts ticks.
    - Press edge with player_num==mem[idx]: go to WAIT_RELEASE.
    - Press edge with a mismatch: go to OVER.
    - Timeout counter reaching TIMEOUT_TICKS: go to OVER.
    - A press edge and the final timeout tick in the same cycle: the press wins.
  - WAIT_RELEASE: no timeout. On the release edge:
    - If idx<level-1: idx++, clear the timeout counter and go to WAIT_PRESS.
    - Else if level==MAX_LEN: go to WIN.
    - Else: level++, simon_turn=1 and go to GEN.
  - OVER: game_over=1, simon_turn=1, simon_pressed=0, level holds its final value.
    - A press edge restarts the game: level=1, game_over=0, state GEN. The LFSR is not reseeded.
  - WIN: win=1, simon_turn=1, simon_pressed=0.
    - A press edge restarts exactly as from OVER and clears win.
- tick arriving in the GEN cycle is ignored. tick counters count only tick pulses, never clk cycles.
- game_over and win are never both 1.

Test Plan:
- Reset behaviour: set MAX_LEN=4, ON=2, OFF=1, TIMEOUT=5, tick every 4th clk; assert reset for 3 cycles -> simon_turn=1, level=1, all other outputs 0. After release, simon_pressed goes high for exactly 2 ticks after 1 tick of gap, then simon_turn=0.
- Correct round: bench echoes each played simon_num as a press followed by a release -> level becomes 2 at the last release+1 and two tones are played back. Round 1's entry is replayed unchanged as entry 0.
- Wrong press: in WAIT_PRESS, press (played value+1)%4 -> game_over=1 one cycle after the edge, simon_turn=1. A second press edge gives level=1, game_over=0 and playback restarts.
- Timeout, plus press/timeout race: hold no button for 5 ticks -> game_over=1. In a rerun, a correct press edge in the same cycle as the 5th tick -> WAIT_RELEASE, no game_over.
- Ignored input and win: pressing during playback changes neither state nor timing. Completing level 4 correctly -> win=1, level=4, game_over=0; a press edge restarts at level=1.
- Reset mid-game: assert reset during ON at level 3 -> next cycle matches the reset values, and the LFSR restarts from 8'hA5, so the first generated entry equals that of the first test.

Source files
------------

// File: rtl/simon_round_controller.sv
// simon_round_controller
//   Sequences one Simon game: grows a random colour sequence by one entry per
//   round, plays it back on the shared LED/speaker path and checks the
//   player's presses against it.
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   tick           single-cycle timing enable; all durations are in ticks
//   player_num     decoded button index, sampled on a press edge
//   player_pressed level, high while any button is held
//   simon_turn     1 = controller owns LEDs/speaker, 0 = player owns them
//   simon_num      colour currently played back
//   simon_pressed  playback tone/LED active
//   game_over      wrong press or timeout
//   win            MAX_LEN round completed
//   level          current sequence length, 1..MAX_LEN
module simon_round_controller #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned ON_TICKS      = 3,
  parameter int unsigned OFF_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 20,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] player_num,
  input  logic       player_pressed,
  output logic       simon_turn,
  output logic [1:0] simon_num,
  output logic       simon_pressed,
  output logic       game_over,
  output logic       win,
  output logic [4:0] level
);

  localparam int unsigned IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned MAXA = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MAXT = (TIMEOUT_TICKS > MAXA) ? TIMEOUT_TICKS : MAXA;
  localparam int unsigned CW   = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    S_GEN,
    S_GAP,
    S_ON,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_OVER,
    S_WIN
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [1:0]    mem [MAX_LEN];
  logic [4:0]    idx;
  logic [CW-1:0] cnt;
  logic          pressed_q;

  logic       press_edge;
  logic       release_edge;
  logic       lfsr_fb;
  logic [4:0] level_m1;

  assign press_edge   = player_pressed & ~pressed_q;
  assign release_edge = ~player_pressed & pressed_q;
  assign lfsr_fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign level_m1     = level - 5'd1;

  // One tick counter is shared: gap length, tone length and the press timeout
  // are never live at the same time. Edges are only acted on in the WAIT and
  // OVER/WIN states, which is what discards input during playback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_GEN;
      lfsr          <= SEED;
      idx           <= '0;
      cnt           <= '0;
      pressed_q     <= 1'b0;
      simon_turn    <= 1'b1;
      simon_num     <= '0;
      simon_pressed <= 1'b0;
      game_over     <= 1'b0;
      win           <= 1'b0;
      level         <= 5'd1;
    end else begin
      lfsr      <= {lfsr[6:0], lfsr_fb};
      pressed_q <= player_pressed;

      unique case (state)
        S_GEN: begin
          mem[level_m1[IW-1:0]] <= lfsr[1:0];
          idx   <= '0;
          cnt   <= '0;
          state <= S_GAP;
        end

        S_GAP: begin
          if (tick) begin
            if (cnt == CW'(OFF_TICKS - 1)) begin
              cnt           <= '0;
              simon_num     <= mem[idx[IW-1:0]];
              simon_pressed <= 1'b1;
              state         <= S_ON;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_ON: begin
          if (tick) begin
            if (cnt == CW'(ON_TICKS - 1)) begin
              cnt           <= '0;
              simon_pressed <= 1'b0;
              if (idx < level_m1) begin
                idx   <= idx + 5'd1;
                state <= S_GAP;
              end else begin
                idx        <= '0;
                simon_turn <= 1'b0;
                state      <= S_WAIT_PRESS;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_WAIT_PRESS: begin
          // A press arriving with the final timeout tick takes priority.
          if (press_edge) begin
            if (player_num == mem[idx[IW-1:0]]) begin
              state <= S_WAIT_RELEASE;
            end else begin
              game_over  <= 1'b1;
              simon_turn <= 1'b1;
              state      <= S_OVER;
            end
          end else if (tick) begin
            if (cnt == CW'(TIMEOUT_TICKS - 1)) begin
              game_over  <= 1'b1;
              simon_turn <= 1'b1;
              state      <= S_OVER;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_WAIT_RELEASE: begin
          if (release_edge) begin
            if (idx < level_m1) begin
              idx   <= idx + 5'd1;
              cnt   <= '0;
              state <= S_WAIT_PRESS;
            end else if (level == 5'(MAX_LEN)) begin
              win        <= 1'b1;
              simon_turn <= 1'b1;
              state      <= S_WIN;
            end else begin
              level      <= level + 5'd1;
              simon_turn <= 1'b1;
              state      <= S_GEN;
            end
          end
        end

        S_OVER, S_WIN: begin
          simon_pressed <= 1'b0;
          simon_turn    <= 1'b1;
          if (press_edge) begin
            level     <= 5'd1;
            game_over <= 1'b0;
            win       <= 1'b0;
            state     <= S_GEN;
          end
        end

        default: state <= S_GEN;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_controller.sv
// tb_simon_round_controller
//   Randomised bench for simon_round_controller. The reference model keeps the
//   expected colour sequence as a queue and predicts each new entry from a
//   free-running model of the LFSR; playback is checked as a list of tones
//   with their on/gap lengths in ticks.
module tb_simon_round_controller;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned ON_T    = 2;
  localparam int unsigned OFF_T   = 1;
  localparam int unsigned TO_T    = 5;
  localparam logic [7:0]  SEED    = 8'hA5;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [1:0] player_num;
  logic       player_pressed;
  logic       simon_turn;
  logic [1:0] simon_num;
  logic       simon_pressed;
  logic       game_over;
  logic       win;
  logic [4:0] level;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_lfsr;
  logic [1:0] seq [$];
  int         cap_num [$];
  int         cap_on [$];
  int         cap_gap [$];
  bit         last_tick;
  int         first_entry;

  simon_round_controller #(
    .MAX_LEN      (MAX_LEN),
    .ON_TICKS     (ON_T),
    .OFF_TICKS    (OFF_T),
    .TIMEOUT_TICKS(TO_T),
    .SEED         (SEED)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .player_num    (player_num),
    .player_pressed(player_pressed),
    .simon_turn    (simon_turn),
    .simon_num     (simon_num),
    .simon_pressed (simon_pressed),
    .game_over     (game_over),
    .win           (win),
    .level         (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick every 4th clock
  initial begin
    int ph;
    ph   = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph   = (ph + 1) % 4;
      tick = (ph == 0);
    end
  end

  // LFSR model: 8-bit Fibonacci, taps 8,6,5,4, stepping every clock
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string pfx, input int lvl, input int go, input int w);
    check({pfx, "_turn"},      simon_turn,    1);
    check({pfx, "_pressed"},   simon_pressed, 0);
    check({pfx, "_game_over"}, game_over,     go);
    check({pfx, "_win"},       win,           w);
    check({pfx, "_level"},     level,         lvl);
  endtask

  // Called #1 after the edge that puts the DUT into GEN: the entry stored in
  // the following cycle is the LFSR value at this moment.
  task automatic note_gen();
    seq.push_back(m_lfsr[1:0]);
  endtask

  // Records tones from the first GAP cycle until the player gets the turn.
  task automatic capture(input bit poke);
    int on_cnt;
    int gap_cnt;
    bit prev_p;
    bit done;
    cap_num.delete();
    cap_on.delete();
    cap_gap.delete();
    on_cnt  = 0;
    gap_cnt = 0;
    prev_p  = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (simon_turn == 1'b0) begin
        done      = 1'b1;
        last_tick = tick;
        if (prev_p) cap_on.push_back(on_cnt);
      end else begin
        if (simon_pressed && !prev_p) begin
          cap_gap.push_back(gap_cnt);
          cap_num.push_back(simon_num);
          gap_cnt = 0;
          on_cnt  = 0;
        end
        if (!simon_pressed && prev_p) cap_on.push_back(on_cnt);
        if (tick) begin
          if (simon_pressed) on_cnt++;
          else               gap_cnt++;
        end
        prev_p = simon_pressed;
        if (poke) begin
          player_pressed = 1'($urandom_range(0, 1));
          player_num     = 2'($urandom_range(0, 3));
        end
      end
    end
    player_pressed = 1'b0;
    check("playback_ends", done, 1);
  endtask

  task automatic verify_playback(input string pfx);
    check({pfx, "_tones"}, cap_num.size(), seq.size());
    for (int i = 0; i < seq.size() && i < cap_num.size(); i++)
      check({pfx, "_tone_num"}, cap_num[i], seq[i]);
    for (int i = 0; i < cap_on.size() && i < seq.size(); i++)
      check({pfx, "_on_ticks"}, cap_on[i], ON_T);
    for (int i = 0; i < cap_gap.size() && i < seq.size(); i++)
      check({pfx, "_gap_ticks"}, cap_gap[i], OFF_T);
    check({pfx, "_level"}, level, seq.size());
  endtask

  task automatic drive_press(input logic [1:0] col);
    @(posedge clk);
    #1;
    player_num     = col;
    player_pressed = 1'b1;
  endtask

  task automatic drive_release();
    @(posedge clk);
    #1;
    player_pressed = 1'b0;
  endtask

  // Echo the whole sequence; ends at the GEN cycle of the next round (or WIN).
  task automatic play_round(input bit poke, input bit do_capture);
    int n;
    n = seq.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drive_press(seq[i]);
      @(posedge clk);
      @(negedge clk);
      check("press_ok_game_over", game_over, 0);
      check("press_ok_turn", simon_turn, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drive_release();
      @(posedge clk);
      #1;
      if (i == n - 1 && n < MAX_LEN) note_gen();
    end
    @(negedge clk);
    if (n == MAX_LEN) begin
      check_idle("win", MAX_LEN, 0, 1);
    end else begin
      check_idle("next_round", n + 1, 0, 0);
      if (do_capture) begin
        capture(poke);
        verify_playback("round");
      end
    end
  endtask

  task automatic restart_game(input string pfx);
    drive_press(2'($urandom_range(0, 3)));
    @(posedge clk);
    #1;
    seq.delete();
    note_gen();
    @(negedge clk);
    check_idle(pfx, 1, 0, 0);
    player_pressed = 1'b0;
    capture(0);
    verify_playback(pfx);
  endtask

  initial begin
    int  cnt;
    bit  seen;
    reset          = 1'b1;
    player_pressed = 1'b0;
    player_num     = 2'd0;
    first_entry    = -1;

    // reset and first playback
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 1, 0, 0);
    check("reset_num", simon_num, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seq.delete();
    note_gen();
    @(negedge clk);
    check_idle("gen", 1, 0, 0);
    capture(0);
    verify_playback("round1");
    if (cap_num.size() > 0) first_entry = cap_num[0];
    check("round1_entry_seed", first_entry, SEED[1:0]);

    // correct round, with button activity during the next playback
    play_round(1, 1);

    // wrong press at level 2
    drive_press(seq[0] + 2'd1);
    @(negedge clk);
    check("wrong_before_edge", game_over, 0);
    @(posedge clk);
    @(negedge clk);
    check_idle("wrong", 2, 1, 0);
    drive_release();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("over_holds", game_over, 1);
    check("over_level", level, 2);
    restart_game("restart_over");

    // timeout with no button
    cnt  = int'(last_tick);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (game_over) seen = 1'b1;
      else if (tick) cnt++;
    end
    check("timeout_seen", seen, 1);
    check("timeout_ticks", cnt, TO_T);
    check_idle("timeout", 1, 1, 0);
    restart_game("restart_timeout");

    // correct press in the same cycle as the final timeout tick
    cnt  = int'(last_tick);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk);
      #2;
      if (tick && cnt == TO_T - 1) begin
        player_num     = seq[0];
        player_pressed = 1'b1;
        seen           = 1'b1;
      end else if (tick) begin
        cnt++;
      end
    end
    check("race_press_driven", seen, 1);
    @(posedge clk);
    @(negedge clk);
    check("race_game_over", game_over, 0);
    check("race_turn", simon_turn, 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("release_wait_no_timeout", game_over, 0);
    drive_release();
    @(posedge clk);
    #1;
    note_gen();
    @(negedge clk);
    check_idle("race_next", 2, 0, 0);
    capture(0);
    verify_playback("race_round");

    // through to the win
    play_round(1, 1);
    play_round(1, 1);
    play_round(0, 1);
    restart_game("restart_win");

    // reset during a tone at level 3
    play_round(0, 1);
    play_round(0, 0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (simon_pressed) seen = 1'b1;
    end
    check("mid_tone_seen", seen, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("midreset", 1, 0, 0);
    check("midreset_num", simon_num, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seq.delete();
    note_gen();
    @(negedge clk);
    check_idle("midreset_gen", 1, 0, 0);
    capture(0);
    verify_playback("after_reset");
    check("after_reset_first", (cap_num.size() > 0) ? cap_num[0] : -1, first_entry);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
